// File: rtl/mux_nto1_stream.sv
`default_nettype none
// ============================================================================
// Module   : mux_nto1_stream
// Summary  : N:1 valid/ready stream multiplexer with a registered output stage.
//            The input channel is chosen by SEL or round-robin across valid channels.
//            If MUX_CNT_EN is defined, the CNT port and a saturating
//            accepted-word counter are added.
// Revision : 1.0 - initial release
// ============================================================================
module mux_nto1_stream #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           MODE,
  input  logic [SW-1:0]  SEL,
  input  logic [N*W-1:0] IN_DATA,
  input  logic [N-1:0]   IN_VALID,
  output logic [N-1:0]   IN_READY,
  output logic [W-1:0]   OUT_DATA,
  output logic           OUT_VALID,
  input  logic           OUT_READY,
  output logic [SW-1:0]  OUT_CH
`ifdef MUX_CNT_EN
  ,
  output logic [15:0]    CNT
`endif
);

  localparam logic [SW-1:0] LAST_CH = SW'(N - 1);

  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_ch_q,    out_ch_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] ptr_q,       ptr_d;

  logic          grant_vld;
  logic [SW-1:0] grant_idx;
  logic [SW-1:0] rr_sel;
  int            rr_idx;
  logic          load;
  logic          accept;

  // The round-robin search runs from the farthest candidate to the nearest one,
  // so the valid channel closest to ptr_q is the last one written and wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_idx    = 0;
    rr_sel    = '0;
    if (!MODE) begin
      for (int i = 0; i < N; i++) begin
        if (SEL == SW'(i) && IN_VALID[i]) begin
          grant_vld = 1'b1;
          grant_idx = SW'(i);
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        rr_idx = int'(ptr_q) + k;
        if (rr_idx >= N) rr_idx = rr_idx - N;
        rr_sel = SW'(rr_idx);
        if (IN_VALID[rr_sel]) begin
          grant_vld = 1'b1;
          grant_idx = rr_sel;
        end
      end
    end
  end

  assign load   = ~out_valid_q | OUT_READY;
  assign accept = grant_vld & load & ~RST;

  always_comb begin
    IN_READY = '0;
    if (accept) IN_READY[grant_idx] = 1'b1;
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_data_d  = IN_DATA[int'(grant_idx)*W +: W];
      out_ch_d    = grant_idx;
      out_valid_d = 1'b1;
      if (MODE) ptr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
    end else if (out_valid_q && OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign OUT_DATA  = out_data_q;
  assign OUT_CH    = out_ch_q;
  assign OUT_VALID = out_valid_q;

`ifdef MUX_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign CNT = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_nto1_stream.sv
`default_nettype none
// Testbench for mux_nto1_stream. It checks a 4-channel instance against a
// behavioural model and a 6-channel instance for out-of-range SEL values.
module tb_mux_nto1_stream;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel DUT
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic [1:0]  sel = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_ch;
`ifdef MUX_CNT_EN
  logic [15:0] cnt;
`endif

  // 6-channel DUT
  logic        rst6 = 1'b1;
  logic        mode6 = 1'b0;
  logic [2:0]  sel6 = '0;
  logic [47:0] in_data6 = '0;
  logic [5:0]  in_valid6 = '0;
  logic [5:0]  in_ready6;
  logic [7:0]  out_data6;
  logic        out_valid6;
  logic        out_ready6 = 1'b0;
  logic [2:0]  out_ch6;
`ifdef MUX_CNT_EN
  logic [15:0] cnt6;
`endif

  mux_nto1_stream #(.N(4), .W(8)) dut (
    .CLK(clk), .RST(rst), .MODE(mode), .SEL(sel), .IN_DATA(in_data),
    .IN_VALID(in_valid), .IN_READY(in_ready), .OUT_DATA(out_data),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_CH(out_ch)
`ifdef MUX_CNT_EN
    , .CNT(cnt)
`endif
  );

  mux_nto1_stream #(.N(6), .W(8)) dut6 (
    .CLK(clk), .RST(rst6), .MODE(mode6), .SEL(sel6), .IN_DATA(in_data6),
    .IN_VALID(in_valid6), .IN_READY(in_ready6), .OUT_DATA(out_data6),
    .OUT_VALID(out_valid6), .OUT_READY(out_ready6), .OUT_CH(out_ch6)
`ifdef MUX_CNT_EN
    , .CNT(cnt6)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model of the 4-channel instance
  bit       m_valid = 0;
  bit [7:0] m_data  = 0;
  int       m_ch    = 0;
  int       m_ptr   = 0;
  int       m_cnt   = 0;

  function automatic int ref_grant();
    if (mode == 1'b0) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] ref_ready();
    int g;
    g = ref_grant();
    if (rst || g < 0 || !(!m_valid || out_ready)) return 4'b0000;
    return 4'(1 << g);
  endfunction

  // Advance one clock: the model takes its decision from the pre-edge inputs
  task automatic step();
    int  g;
    bit  acc;
    g   = ref_grant();
    acc = !rst && (g >= 0) && (!m_valid || out_ready);
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0; m_cnt = 0;
    end else if (acc) begin
      m_data  = in_data[g*8 +: 8];
      m_ch    = g;
      m_valid = 1;
      if (mode) m_ptr = (g + 1) % 4;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; rst6 = 1; in_valid = 4'hF; in_valid6 = 6'h3F; out_ready = 1; out_ready6 = 1;
    in_data = 32'h4433_2211;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        errors++; $display("FAIL reset_in_ready cyc%0d: got %b want 0000", c, in_ready);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
      errors++; $display("FAIL reset_outputs: got v=%b d=%h ch=%0d want v=0 d=00 ch=0", out_valid, out_data, out_ch);
    end
    checks++;
    if (out_valid6 !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid6: got %b want 0", out_valid6);
    end
`ifdef MUX_CNT_EN
    checks++;
    if (cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", cnt);
    end
`endif
  endtask

  task automatic test_explicit();
    rst = 0; mode = 0; sel = 2; in_valid = 4'b0100; in_data = 32'h00A5_0000; out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++; $display("FAIL explicit_in_ready: got %b want 0100", in_ready);
    end
    step();
    checks++;
    if (out_data !== 8'hA5 || out_ch !== 2'd2 || out_valid !== 1'b1) begin
      errors++; $display("FAIL explicit_out: got d=%h ch=%0d v=%b want d=a5 ch=2 v=1", out_data, out_ch, out_valid);
    end
  endtask

  task automatic test_round_robin();
    int exp_ch [6] = '{0, 1, 2, 3, 0, 1};
    mode = 1; in_valid = 4'hF; in_data = 32'h1312_1110; out_ready = 1;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (out_ch !== 2'(exp_ch[c]) || out_data !== 8'(8'h10 + exp_ch[c]) || out_valid !== 1'b1) begin
        errors++; $display("FAIL rr_seq cyc%0d: got ch=%0d d=%h v=%b want ch=%0d d=%h v=1",
                           c, out_ch, out_data, out_valid, exp_ch[c], 8'h10 + exp_ch[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    mode = 0; sel = 1; in_valid = 4'b0010; in_data = 32'h3300_1100; out_ready = 1;
    step();
    sel = 3; in_valid = 4'b1000; out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_in_ready cyc%0d: got %b want 0000", c, in_ready);
      end
      step();
      checks++;
      if (out_data !== 8'h11 || out_ch !== 2'd1 || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold cyc%0d: got d=%h ch=%0d v=%b want d=11 ch=1 v=1", c, out_data, out_ch, out_valid);
      end
    end
    out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin
      errors++; $display("FAIL bp_release_ready: got %b want 1000", in_ready);
    end
    step();
    checks++;
    if (out_ch !== 2'd3 || out_data !== 8'h33 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_release_out: got ch=%0d d=%h v=%b want ch=3 d=33 v=1", out_ch, out_data, out_valid);
    end
    in_valid = 4'b0000;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_sel_out_of_range();
    rst6 = 0; mode6 = 0; sel6 = 4; in_valid6 = 6'h3F; out_ready6 = 1;
    in_data6 = 48'h5544_3322_1100;
    step();
    checks++;
    if (out_valid6 !== 1'b1 || out_ch6 !== 3'd4 || out_data6 !== 8'h44) begin
      errors++; $display("FAIL sel6_in_range: got v=%b ch=%0d d=%h want v=1 ch=4 d=44", out_valid6, out_ch6, out_data6);
    end
    sel6 = 7;
    #1;
    checks++;
    if (in_ready6 !== 6'b000000) begin
      errors++; $display("FAIL sel6_oor_ready: got %b want 000000", in_ready6);
    end
    step();
    checks++;
    if (out_valid6 !== 1'b0) begin
      errors++; $display("FAIL sel6_oor_valid: got %b want 0", out_valid6);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 59) == 0);
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      checks++;
      if (in_ready !== ref_ready()) begin
        errors++; $display("FAIL rand_in_ready cyc%0d: got %b want %b", c, in_ready, ref_ready());
      end
      step();
      checks++;
      if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_ch !== 2'(m_ch)))) begin
        errors++; $display("FAIL rand_out cyc%0d: got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d",
                           c, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
      end
`ifdef MUX_CNT_EN
      checks++;
      if (cnt !== 16'(m_cnt)) begin
        errors++; $display("FAIL rand_cnt cyc%0d: got %0d want %0d", c, cnt, m_cnt);
      end
`endif
    end
    rst = 0;
  endtask

`ifdef MUX_CNT_EN
  task automatic test_counter();
    rst = 1; step();
    rst = 0; mode = 0; sel = 0; in_valid = 4'b0001; out_ready = 1; in_data = 32'h0000_00C3;
    for (int c = 0; c < 10; c++) step();
    checks++;
    if (cnt !== 16'd10) begin
      errors++; $display("FAIL cnt_ten: got %0d want 10", cnt);
    end
    rst = 1;
    step();
    checks++;
    if (cnt !== 16'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL cnt_reset: got cnt=%0d v=%b want cnt=0 v=0", cnt, out_valid);
    end
    rst = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_explicit();
    test_round_robin();
    test_backpressure();
    test_sel_out_of_range();
    test_random();
`ifdef MUX_CNT_EN
    test_counter();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
